matrix_tile_scheduler: RTL and testbench
========================================

MATRIX_TILE_SCHEDULER -- requirements
Module: matrix_tile_scheduler

Interface
REQ-001 SHALL have parameter TILES_X, default 50, meaning 16-px-wide tiles per band (800/16).
REQ-002 SHALL have parameter BANDS, default 75, meaning 8-row bands per frame (600/8).
REQ-003 SHALL have parameter TILE_H, default 8, meaning rows per band.
REQ-004 SHALL have port clk  in  1  system clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  scheduling enable; when low no new band is started.
REQ-007 SHALL have port vid_vs, vid_de  in  1 each  video timing, already synchronous to clk.
REQ-008 SHALL have port job_valid  out  1  tile job offered to SPI master.
REQ-009 SHALL have port job_ready  in  1  SPI master accepts job.
REQ-010 SHALL have port job_tile  out  clog2(TILES_X)  tile column of offered job.
REQ-011 SHALL have port job_band  out  clog2(BANDS)  band row of offered job.
REQ-012 SHALL have port job_last  out  1  offered job is last tile of last band.
REQ-013 SHALL have port job_done  in  1  one-cycle pulse: accepted job finished transmitting.
REQ-014 SHALL have port ovf_clr  in  1  clears sticky overflow.
REQ-015 SHALL have port overflow  out  1  sticky: completed band dropped.
REQ-016 SHALL have port frame_cnt  out  16  frames seen (vid_vs rising edges), wraps.

Function
REQ-017 SHALL register vid_vs and vid_de once; row-end = de_q & ~vid_de, frame-start = vid_vs & ~vs_q.
REQ-018 SHALL count row-ends 0..TILE_H-1; on row-end at TILE_H-1 emit band_avail, reset row count, increment band_wr (stop at BANDS; further band_avail ignored).
REQ-019 SHALL hold pending band count 0..2: +1 on band_avail, -1 on band consumed, unchanged if both same cycle.
REQ-020 SHALL, on band_avail with pending==2 and no same-cycle consume, drop the band and set overflow; overflow clears only on ovf_clr (set wins if simultaneous).
REQ-021 SHALL, on frame-start: row count, band_wr, band_rd, pending := 0; frame_cnt += 1; frame-start overrides same-cycle row-end.
REQ-022 SHALL implement FSM IDLE, ISSUE, WAIT_DONE, NEXT.
REQ-023 IDLE -> ISSUE when enable & pending>0; tile := 0.
REQ-024 ISSUE: job_valid=1, job_tile=tile, job_band=band_rd; on job_ready -> WAIT_DONE; outputs stable while valid & ~ready.
REQ-025 WAIT_DONE -> NEXT on job_done; job_done outside WAIT_DONE ignored.
REQ-026 NEXT: tile<TILES_X-1 -> tile+1, ISSUE; else band consumed (band_rd+1, pending-1) -> IDLE; one-cycle state.
REQ-027 SHALL keep job_valid asserted through frame-start until accepted; frame-start only affects counters, and the in-flight band completes with its latched job_band.
REQ-028 job_last SHALL equal (tile==TILES_X-1)&(band_rd==BANDS-1) while job_valid.
REQ-029 Latency: band_avail to job_valid = 2 cycles when IDLE and enable.
REQ-030 Deasserting enable SHALL NOT abort a started band.

Reset
REQ-031 On rst_n low: state IDLE, job_valid 0, job_tile 0, job_band 0, job_last 0, overflow 0, frame_cnt 0, all counters and sync registers 0.
REQ-032 Reset SHALL act mid-job immediately; no job_done is awaited after release.

Structure
REQ-033 SHALL place FSM state enum and default TILES_X/BANDS/TILE_H constants in shared package matrix_pkg.
REQ-034 SHALL use one sub-module video_band_tracker (REQ-017..021 edge detection, row/band counting, pending, overflow).

Verification
REQ-035 TILES_X=4,BANDS=2: 8 row-ends -> 4 jobs band 0, tiles 0..3; job_last 0.
REQ-036 Hold job_ready low 5 cycles -> job_valid/job_tile/job_band stable; accept on ready.
REQ-037 Three bands complete with no job_done -> pending 2, overflow 1; ovf_clr -> overflow 0.
REQ-038 vid_vs rising during WAIT_DONE band 1 -> band 1 finishes, frame_cnt+1, next job band 0.
REQ-039 Assert rst_n low during ISSUE -> job_valid 0 next edge, all outputs reset.
REQ-040 Second band, last tile -> job_last 1 only on tile 3 band 1.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the tile scheduler slice:
//   - sched_state_t : tile-issue FSM state encoding
//   - DEF_*         : default panel geometry (800x600 panel, 16x8 tiles)
//   - idx_w()       : index width helper that never returns zero
// -----------------------------------------------------------------------------
package matrix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_NEXT      = 2'd3
   } sched_state_t;

   localparam int DEF_TILES_X = 50;  // 800 / 16
   localparam int DEF_BANDS   = 75;  // 600 / 8
   localparam int DEF_TILE_H  = 8;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/video_band_tracker.sv
// -----------------------------------------------------------------------------
// video_band_tracker
// Watches the video timing, counts rows into bands and keeps the queue of
// bands that are ready for transmission.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   vid_vs/vid_de : video timing, synchronous to clk
//   band_consume  : scheduler finished all tiles of the oldest pending band
//   ovf_clr       : clears the sticky overflow flag
//   frame_start   : combinational pulse on vid_vs rising edge
//   pending       : number of complete, unsent bands (0..2)
//   band_rd       : band index the scheduler should send next
//   overflow      : sticky, a completed band was dropped
//   frame_cnt     : wrapping count of frame starts
// -----------------------------------------------------------------------------
module video_band_tracker
   import matrix_pkg::*;
#(
   parameter int BANDS  = DEF_BANDS,
   parameter int TILE_H = DEF_TILE_H
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vid_vs,
   input  logic                     vid_de,
   input  logic                     band_consume,
   input  logic                     ovf_clr,
   output logic                     frame_start,
   output logic [1:0]               pending,
   output logic [idx_w(BANDS)-1:0]  band_rd,
   output logic                     overflow,
   output logic [15:0]              frame_cnt
);

   localparam int RW = idx_w(TILE_H);
   localparam int WW = $clog2(BANDS + 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);
   localparam logic [WW-1:0] WR_FULL  = WW'(BANDS);

   logic          vs_p0;
   logic          de_p0;
   logic          row_end;
   logic          band_avail;
   logic          consume_ok;
   logic          drop;
   logic [RW-1:0] row_cnt;
   logic [WW-1:0] band_wr;

   assign frame_start = vid_vs & ~vs_p0;
   assign row_end     = de_p0 & ~vid_de;

   // A frame start wins over a coincident row end, and once every band of the
   // frame has been announced further band ends are ignored.
   assign band_avail = row_end & (row_cnt == ROW_LAST) & ~frame_start
                     & (band_wr != WR_FULL);

   // A consume can only retire a band that is still counted in this frame.
   assign consume_ok = band_consume & (pending != 2'd0) & ~frame_start;

   // Queue is two deep; a third band with no simultaneous retire is lost.
   assign drop = band_avail & ~consume_ok & (pending == 2'd2);

   // Stage p0: timing sync registers and band bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_p0     <= 1'b0;
         de_p0     <= 1'b0;
         row_cnt   <= '0;
         band_wr   <= '0;
         band_rd   <= '0;
         pending   <= 2'd0;
         overflow  <= 1'b0;
         frame_cnt <= 16'd0;
      end else begin
         vs_p0 <= vid_vs;
         de_p0 <= vid_de;

         if (frame_start) begin
            row_cnt   <= '0;
            band_wr   <= '0;
            band_rd   <= '0;
            pending   <= 2'd0;
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            if (row_end)
               row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            if (band_avail)
               band_wr <= band_wr + 1'b1;
            if (consume_ok)
               band_rd <= band_rd + 1'b1;
            case ({band_avail & ~drop, consume_ok})
               2'b10:   pending <= pending + 2'd1;
               2'b01:   pending <= pending - 2'd1;
               default: pending <= pending;
            endcase
         end

         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/matrix_tile_scheduler.sv
// -----------------------------------------------------------------------------
// matrix_tile_scheduler
// Turns completed video bands into a stream of per-tile transmit jobs for an
// SPI master. One job is offered at a time; the next tile is offered only
// after the previous one reports job_done.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : allows a new band to be started (never aborts one)
//   vid_vs, vid_de  : video timing, synchronous to clk
//   job_valid/ready : job offer handshake
//   job_tile/band   : tile column and band row of the offered job
//   job_last        : offered job is the final tile of the final band
//   job_done        : pulse, accepted job finished transmitting
//   ovf_clr         : clears sticky overflow
//   overflow        : sticky, a completed band was dropped
//   frame_cnt       : wrapping count of frame starts
// -----------------------------------------------------------------------------
module matrix_tile_scheduler
   import matrix_pkg::*;
#(
   parameter int TILES_X = DEF_TILES_X,
   parameter int BANDS   = DEF_BANDS,
   parameter int TILE_H  = DEF_TILE_H
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       vid_vs,
   input  logic                       vid_de,
   output logic                       job_valid,
   input  logic                       job_ready,
   output logic [idx_w(TILES_X)-1:0]  job_tile,
   output logic [idx_w(BANDS)-1:0]    job_band,
   output logic                       job_last,
   input  logic                       job_done,
   input  logic                       ovf_clr,
   output logic                       overflow,
   output logic [15:0]                frame_cnt
);

   localparam int TW = idx_w(TILES_X);
   localparam int BW = idx_w(BANDS);
   localparam logic [TW-1:0] LAST_TILE = TW'(TILES_X - 1);
   localparam logic [BW-1:0] LAST_BAND = BW'(BANDS - 1);

   sched_state_t  state, state_d;
   logic [TW-1:0] tile, tile_d;
   logic [BW-1:0] cur_band, cur_band_d;
   logic          stale, stale_d;
   logic          band_consume;
   logic          frame_start;
   logic [1:0]    pending;
   logic [BW-1:0] band_rd;

   video_band_tracker #(
      .BANDS  (BANDS),
      .TILE_H (TILE_H)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .vid_vs       (vid_vs),
      .vid_de       (vid_de),
      .band_consume (band_consume),
      .ovf_clr      (ovf_clr),
      .frame_start  (frame_start),
      .pending      (pending),
      .band_rd      (band_rd),
      .overflow     (overflow),
      .frame_cnt    (frame_cnt)
   );

   // The band index is latched when a band starts so a frame start mid-band
   // does not change job_band. 'stale' marks such a band: its counters were
   // already cleared, so finishing it must not retire a band of the new frame.
   always_comb begin
      state_d      = state;
      tile_d       = tile;
      cur_band_d   = cur_band;
      stale_d      = stale;
      band_consume = 1'b0;

      if (frame_start && (state != ST_IDLE))
         stale_d = 1'b1;

      case (state)
         ST_IDLE: begin
            if (enable && (pending != 2'd0)) begin
               state_d    = ST_ISSUE;
               tile_d     = '0;
               cur_band_d = band_rd;
               stale_d    = frame_start;
            end
         end
         ST_ISSUE: begin
            if (job_ready)
               state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (job_done)
               state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (tile == LAST_TILE) begin
               band_consume = ~stale;
               state_d      = ST_IDLE;
            end else begin
               tile_d  = tile + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage p0: scheduler state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tile     <= '0;
         cur_band <= '0;
         stale    <= 1'b0;
      end else begin
         state    <= state_d;
         tile     <= tile_d;
         cur_band <= cur_band_d;
         stale    <= stale_d;
      end
   end

   assign job_valid = (state == ST_ISSUE);
   assign job_tile  = tile;
   assign job_band  = cur_band;
   assign job_last  = job_valid & (tile == LAST_TILE) & (cur_band == LAST_BAND);

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_matrix_tile_scheduler
// Directed bench: a 4-tile x 2-band scheduler plus a 4-band twin that shares
// all stimulus, used where the queue must overflow within one frame.
// -----------------------------------------------------------------------------
module tb_matrix_tile_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        vid_vs;
   logic        vid_de;
   logic        job_ready;
   logic        job_done;
   logic        ovf_clr;

   logic        job_valid;
   logic [1:0]  job_tile;
   logic [0:0]  job_band;
   logic        job_last;
   logic        overflow;
   logic [15:0] frame_cnt;

   logic        job_valid2;
   logic [1:0]  job_tile2;
   logic [1:0]  job_band2;
   logic        job_last2;
   logic        overflow2;
   logic [15:0] frame_cnt2;

   int passes = 0;
   int total  = 0;

   matrix_tile_scheduler #(.TILES_X(4), .BANDS(2), .TILE_H(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .vid_vs    (vid_vs),
      .vid_de    (vid_de),
      .job_valid (job_valid),
      .job_ready (job_ready),
      .job_tile  (job_tile),
      .job_band  (job_band),
      .job_last  (job_last),
      .job_done  (job_done),
      .ovf_clr   (ovf_clr),
      .overflow  (overflow),
      .frame_cnt (frame_cnt)
   );

   matrix_tile_scheduler #(.TILES_X(4), .BANDS(4), .TILE_H(8)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .vid_vs    (vid_vs),
      .vid_de    (vid_de),
      .job_valid (job_valid2),
      .job_ready (job_ready),
      .job_tile  (job_tile2),
      .job_band  (job_band2),
      .job_last  (job_last2),
      .job_done  (job_done),
      .ovf_clr   (ovf_clr),
      .overflow  (overflow2),
      .frame_cnt (frame_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Eight row ends: each row is one cycle of de high then one low.
   task automatic band();
      for (int r = 0; r < 8; r++) begin
         vid_de = 1'b1;
         tick();
         vid_de = 1'b0;
         tick();
      end
   endtask

   task automatic pulse_vs();
      vid_vs = 1'b1;
      tick();
      vid_vs = 1'b0;
   endtask

   // Check the offered job, accept it, complete it, and step past NEXT.
   task automatic do_job(input string tag, input int t, input int b, input int last);
      check({tag, ".valid"}, job_valid, 1);
      check({tag, ".tile"},  job_tile,  t);
      check({tag, ".band"},  job_band,  b);
      check({tag, ".last"},  job_last,  last);
      job_ready = 1'b1;
      tick();
      job_ready = 1'b0;
      check({tag, ".accepted"}, job_valid, 0);
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      vid_vs    = 1'b0;
      vid_de    = 1'b0;
      job_ready = 1'b0;
      job_done  = 1'b0;
      ovf_clr   = 1'b0;

      // reset state
      tick();
      tick();
      check("rst.valid",    job_valid, 0);
      check("rst.tile",     job_tile,  0);
      check("rst.band",     job_band,  0);
      check("rst.last",     job_last,  0);
      check("rst.overflow", overflow,  0);
      check("rst.frame",    frame_cnt, 0);
      rst_n = 1'b1;
      tick();

      // frame 1
      pulse_vs();
      check("f1.frame_cnt", frame_cnt, 1);
      tick();
      enable = 1'b1;

      // band 0: job appears two edges after the band completes
      band();
      check("lat.not_yet", job_valid, 0);
      tick();
      check("lat.valid", job_valid, 1);

      // back-pressure: offer must hold still
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold.valid", job_valid, 1);
         check("hold.tile",  job_tile,  0);
         check("hold.band",  job_band,  0);
      end

      do_job("b0t0", 0, 0, 0);
      do_job("b0t1", 1, 0, 0);
      do_job("b0t2", 2, 0, 0);
      do_job("b0t3", 3, 0, 0);
      check("b0.idle", job_valid, 0);

      // band 1: last tile of last band flags job_last
      band();
      tick();
      do_job("b1t0", 0, 1, 0);
      do_job("b1t1", 1, 1, 0);
      do_job("b1t2", 2, 1, 0);
      do_job("b1t3", 3, 1, 1);
      check("b1.idle", job_valid, 0);

      // frame 2: frame start while band 1 waits for job_done
      pulse_vs();
      check("f2.frame_cnt", frame_cnt, 2);
      tick();
      band();
      tick();
      do_job("f2b0t0", 0, 0, 0);
      do_job("f2b0t1", 1, 0, 0);
      do_job("f2b0t2", 2, 0, 0);
      do_job("f2b0t3", 3, 0, 0);
      band();
      tick();
      check("f2b1.tile", job_tile, 0);
      check("f2b1.band", job_band, 1);
      job_ready = 1'b1;
      tick();
      job_ready = 1'b0;
      pulse_vs();
      check("f3.frame_cnt", frame_cnt, 3);
      check("f3.waiting",   job_valid, 0);
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      tick();
      do_job("f2b1t1", 1, 1, 0);
      do_job("f2b1t2", 2, 1, 0);
      do_job("f2b1t3", 3, 1, 1);
      check("f3.idle", job_valid, 0);
      tick();
      tick();
      check("f3.nothing_pending", job_valid, 0);
      band();
      tick();
      check("f3b0.valid", job_valid, 1);
      check("f3b0.tile",  job_tile,  0);
      check("f3b0.band",  job_band,  0);

      // frame 4: job stays offered across the frame start; queue overflows
      pulse_vs();
      check("f4.frame_cnt",  frame_cnt,  4);
      check("f4.frame_cnt4", frame_cnt2, 4);
      check("f4.valid_kept", job_valid,  1);
      band();
      band();
      check("ovf.two_pending", overflow2, 0);
      band();
      check("ovf.dropped",      overflow2,  1);
      check("ovf.band_cap",     overflow,   0);
      tick();
      check("ovf.sticky",       overflow2,  1);
      check("ovf4.valid",       job_valid2, 1);
      check("ovf4.tile",        job_tile2,  0);
      check("ovf4.band",        job_band2,  0);
      check("ovf4.last",        job_last2,  0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf.cleared", overflow2, 0);

      // reset in the middle of an offered job
      check("mid.valid", job_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid.rst_valid", job_valid, 0);
      check("mid.rst_tile",  job_tile,  0);
      check("mid.rst_band",  job_band,  0);
      check("mid.rst_last",  job_last,  0);
      check("mid.rst_frame", frame_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("post.no_job", job_valid, 0);
      band();
      tick();
      check("post.valid", job_valid, 1);
      check("post.tile",  job_tile,  0);
      check("post.band",  job_band,  0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
